// File: rtl/johnson_phase_monitor_if.sv
// Bus between a Johnson-code source and johnson_phase_monitor.
// master: drives Enable/Clear/Count_in. slave: drives the decoded status.
interface johnson_phase_monitor_if #(
    parameter int ERR_W = 8,
    parameter int REV_W = 16
);
    logic             Enable;
    logic             Clear;
    logic [3:0]       Count_in;
    logic [7:0]       Phase_out;
    logic [2:0]       Phase_idx;
    logic             Locked;
    logic             Error_pulse;
    logic [ERR_W-1:0] Err_count;
    logic             Rev_pulse;
    logic [REV_W-1:0] Rev_count;

    modport master (
        output Enable, Clear, Count_in,
        input  Phase_out, Phase_idx, Locked,
        input  Error_pulse, Err_count, Rev_pulse, Rev_count
    );

    modport slave (
        input  Enable, Clear, Count_in,
        output Phase_out, Phase_idx, Locked,
        output Error_pulse, Err_count, Rev_pulse, Rev_count
    );
endinterface

// File: rtl/johnson_phase_monitor.sv
// Johnson phase monitor: decodes a 4-bit Johnson code, tracks lock,
// counts transition errors (saturating) and revolutions (wrapping).
// Ports: Clock, Reset (async, active-low), mon (slave modport):
//   in  Enable, Clear, Count_in[3:0]
//   out Phase_out[7:0], Phase_idx[2:0], Locked, Error_pulse,
//       Err_count[ERR_W-1:0], Rev_pulse, Rev_count[REV_W-1:0]
// Option: JOHNSON_MONITOR_RESYNC_EN makes a jump to 0000 a silent resync.
module johnson_phase_monitor #(
    parameter int LOCK_COUNT = 4,
    parameter int ERR_W      = 8,
    parameter int REV_W      = 16
) (
    input logic Clock,
    input logic Reset,
    johnson_phase_monitor_if.slave mon
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACQ    = 2'd1;
    localparam logic [1:0] S_LOCKED = 2'd2;
    localparam logic [3:0] LOCK_MAX = 4'(LOCK_COUNT);

    logic [3:0]       samp;
    logic [3:0]       prev;
    logic             samp_vld;
    logic [1:0]       state;
    logic [3:0]       lock_cnt;
    logic [7:0]       phase_q;
    logic [2:0]       idx_q;
    logic             err_p_q;
    logic             rev_p_q;
    logic [ERR_W-1:0] err_q;
    logic [REV_W-1:0] rev_q;

    logic       legal;
    logic [2:0] dec_idx;
    logic [3:0] nxt;
    logic       cls_stall;
    logic       cls_step;
    logic       zero_jump;
    logic       cls_resync;
    logic       cls_error;
    logic       fire;
    logic       err_hit;
    logic       rev_hit;

    always_comb begin
        legal   = 1'b1;
        dec_idx = 3'd0;
        unique case (samp)
            4'b0000: dec_idx = 3'd0;
            4'b0001: dec_idx = 3'd1;
            4'b0011: dec_idx = 3'd2;
            4'b0111: dec_idx = 3'd3;
            4'b1111: dec_idx = 3'd4;
            4'b1110: dec_idx = 3'd5;
            4'b1100: dec_idx = 3'd6;
            4'b1000: dec_idx = 3'd7;
            default: legal   = 1'b0;
        endcase
    end

    assign nxt       = {prev[2:0], ~prev[3]};
    assign cls_stall = legal && (samp == prev);
    assign cls_step  = legal && !cls_stall && (samp == nxt);
    assign zero_jump = legal && !cls_stall && !cls_step
                     && (samp == 4'b0000);

`ifdef JOHNSON_MONITOR_RESYNC_EN
    assign cls_resync = zero_jump;
    assign cls_error  = !(cls_stall || cls_step || zero_jump);
`else
    assign cls_resync = 1'b0;
    assign cls_error  = !(cls_stall || cls_step);
`endif

    // Stage 2 runs only once stage 1 holds a real sample, so the
    // reset value of samp is never mistaken for the IDLE entry code.
    assign fire    = mon.Enable && samp_vld;
    assign err_hit = fire && (state != S_IDLE) && cls_error;
    assign rev_hit = fire && (state == S_LOCKED) && cls_step
                   && (prev == 4'b1000);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            samp     <= '0;
            prev     <= '0;
            samp_vld <= 1'b0;
            state    <= S_IDLE;
            lock_cnt <= '0;
            phase_q  <= '0;
            idx_q    <= '0;
            err_p_q  <= 1'b0;
            rev_p_q  <= 1'b0;
            err_q    <= '0;
            rev_q    <= '0;
        end else begin
            err_p_q <= err_hit;
            rev_p_q <= rev_hit;
            if (mon.Enable) begin
                samp     <= mon.Count_in;
                samp_vld <= 1'b1;
            end
            if (fire) begin
                prev <= samp;
                if (legal) begin
                    phase_q <= 8'b1 << dec_idx;
                    idx_q   <= dec_idx;
                end else begin
                    phase_q <= '0;
                end
                unique case (state)
                    S_IDLE: begin
                        state    <= S_ACQ;
                        lock_cnt <= '0;
                    end
                    S_ACQ: begin
                        if (cls_error || cls_resync) begin
                            lock_cnt <= '0;
                        end else if (cls_step) begin
                            if (lock_cnt >= LOCK_MAX - 4'd1) begin
                                lock_cnt <= LOCK_MAX;
                                state    <= S_LOCKED;
                            end else begin
                                lock_cnt <= lock_cnt + 4'd1;
                            end
                        end
                    end
                    S_LOCKED: begin
                        if (cls_error || cls_resync) begin
                            state    <= S_ACQ;
                            lock_cnt <= '0;
                        end
                    end
                    default: begin
                        state    <= S_IDLE;
                        lock_cnt <= '0;
                    end
                endcase
            end
            if (mon.Clear) begin
                err_q <= '0;
            end else if (err_hit && (err_q != '1)) begin
                err_q <= err_q + ERR_W'(1);
            end
            if (mon.Clear) begin
                rev_q <= '0;
            end else if (rev_hit) begin
                rev_q <= rev_q + REV_W'(1);
            end
        end
    end

    assign mon.Phase_out   = phase_q;
    assign mon.Phase_idx   = idx_q;
    assign mon.Locked      = (state == S_LOCKED);
    assign mon.Error_pulse = err_p_q;
    assign mon.Err_count   = err_q;
    assign mon.Rev_pulse   = rev_p_q;
    assign mon.Rev_count   = rev_q;
endmodule

// File: tb/tb_johnson_phase_monitor.sv
// Scoreboard bench for johnson_phase_monitor (LOCK_COUNT=4, ERR_W=2,
// REV_W=2). Driver queues expected outputs; monitor pops and compares.
module tb_johnson_phase_monitor;
`ifdef JOHNSON_MONITOR_RESYNC_EN
    localparam int RS = 1;
`else
    localparam int RS = 0;
`endif
    localparam int EC = (RS != 0) ? 0 : 1;

    typedef struct {
        int         at;
        string      nm;
        logic [7:0] ph;
        logic [2:0] idx;
        logic       lk;
        logic       ep;
        logic [1:0] ec;
        logic       rp;
        logic [1:0] rc;
    } exp_t;

    logic Clock = 1'b0;
    logic Reset;
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_pass = 0;
    exp_t q[$];
    event ev_async;

    johnson_phase_monitor_if #(.ERR_W(2), .REV_W(2)) bus ();

    johnson_phase_monitor #(
        .LOCK_COUNT(4),
        .ERR_W(2),
        .REV_W(2)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .mon(bus)
    );

    always #5 Clock = ~Clock;

    initial forever begin
        @(posedge Clock);
        cyc++;
    end

    initial forever begin
        exp_t e;
        logic [17:0] act;
        logic [17:0] req;
        @(negedge Clock or ev_async);
        while (q.size() > 0 && q[0].at <= cyc) begin
            e = q.pop_front();
            act = {bus.Phase_out, bus.Phase_idx, bus.Locked,
                   bus.Error_pulse, bus.Err_count,
                   bus.Rev_pulse, bus.Rev_count};
            req = {e.ph, e.idx, e.lk, e.ep, e.ec, e.rp, e.rc};
            n_chk++;
            if (act === req) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got ph=%h idx=%0d lk=%b ep=%b ec=%0d rp=%b rc=%0d, want ph=%h idx=%0d lk=%b ep=%b ec=%0d rp=%b rc=%0d",
                         e.nm, act[17:10], act[9:7], act[6], act[5],
                         act[4:3], act[2], act[1:0], e.ph, e.idx,
                         e.lk, e.ep, e.ec, e.rp, e.rc);
            end
        end
    end

    function automatic exp_t mk(input int at, input string nm,
                                input int ph, input int idx,
                                input int lk, input int ep,
                                input int ec, input int rp,
                                input int rc);
        exp_t e;
        e.at  = at;
        e.nm  = nm;
        e.ph  = 8'(ph);
        e.idx = 3'(idx);
        e.lk  = 1'(lk);
        e.ep  = 1'(ep);
        e.ec  = 2'(ec);
        e.rp  = 1'(rp);
        e.rc  = 2'(rc);
        return e;
    endfunction

    // Inputs for the coming edge; expectation = outputs after that edge.
    task automatic v(input string nm, input logic rst, input logic en,
                     input logic clr, input logic [3:0] c,
                     input int ph, input int idx, input int lk,
                     input int ep, input int ec, input int rp,
                     input int rc);
        Reset        = rst;
        bus.Enable   = en;
        bus.Clear    = clr;
        bus.Count_in = c;
        q.push_back(mk(cyc + 1, nm, ph, idx, lk, ep, ec, rp, rc));
        @(posedge Clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] jc [8];
        int         rc5 [5];
        jc  = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                4'b1111, 4'b1110, 4'b1100, 4'b1000};
        rc5 = '{1, 2, 3, 0, 1};
        Reset        = 1'b0;
        bus.Enable   = 1'b0;
        bus.Clear    = 1'b0;
        bus.Count_in = 4'b0000;

        v("rst",     0, 0, 0, 4'b0000, 'h00, 0, 0, 0, 0, 0, 0);
        v("rel",     1, 1, 0, 4'b0000, 'h00, 0, 0, 0, 0, 0, 0);
        v("idle",    1, 1, 0, 4'b0001, 'h01, 0, 0, 0, 0, 0, 0);
        v("acq1",    1, 1, 0, 4'b0011, 'h02, 1, 0, 0, 0, 0, 0);
        v("acq2",    1, 1, 0, 4'b0111, 'h04, 2, 0, 0, 0, 0, 0);
        v("acq3",    1, 1, 0, 4'b1111, 'h08, 3, 0, 0, 0, 0, 0);
        v("lock",    1, 1, 0, 4'b1110, 'h10, 4, 1, 0, 0, 0, 0);
        v("lk5",     1, 1, 0, 4'b1100, 'h20, 5, 1, 0, 0, 0, 0);
        v("lk6",     1, 1, 0, 4'b1000, 'h40, 6, 1, 0, 0, 0, 0);
        v("lk7",     1, 1, 0, 4'b0000, 'h80, 7, 1, 0, 0, 0, 0);
        v("rev1",    1, 1, 0, 4'b0001, 'h01, 0, 1, 0, 0, 1, 1);
        v("lk1",     1, 1, 0, 4'b0011, 'h02, 1, 1, 0, 0, 0, 1);
        v("hold1",   1, 0, 0, 4'b0111, 'h02, 1, 1, 0, 0, 0, 1);
        v("hold2",   1, 0, 0, 4'b1111, 'h02, 1, 1, 0, 0, 0, 1);
        v("resume",  1, 1, 0, 4'b0111, 'h04, 2, 1, 0, 0, 0, 1);
        v("lk3",     1, 1, 0, 4'b1111, 'h08, 3, 1, 0, 0, 0, 1);
        v("lk4",     1, 1, 0, 4'b1110, 'h10, 4, 1, 0, 0, 0, 1);
        v("pre_bad", 1, 1, 0, 4'b0101, 'h20, 5, 1, 0, 0, 0, 1);
        v("bad",     1, 1, 0, 4'b1100, 'h00, 5, 0, 1, 1, 0, 1);
        v("rejoin",  1, 1, 0, 4'b1000, 'h40, 6, 0, 1, 2, 0, 1);
        v("racq1",   1, 1, 0, 4'b0000, 'h80, 7, 0, 0, 2, 0, 1);
        v("racq2",   1, 1, 0, 4'b0001, 'h01, 0, 0, 0, 2, 0, 1);
        v("racq3",   1, 1, 0, 4'b0011, 'h02, 1, 0, 0, 2, 0, 1);
        v("relock",  1, 1, 0, 4'b0000, 'h04, 2, 1, 0, 2, 0, 1);
        v("zero_jmp", 1, 1, 0, 4'b0000, 'h01, 0, 0,
          (RS != 0) ? 0 : 1, (RS != 0) ? 2 : 3, 0, 1);
        v("clear",   1, 1, 1, 4'b0001, 'h01, 0, 0, 0, 0, 0, 0);
        v("c_acq1",  1, 1, 0, 4'b0011, 'h02, 1, 0, 0, 0, 0, 0);
        v("c_acq2",  1, 1, 0, 4'b0111, 'h04, 2, 0, 0, 0, 0, 0);
        v("c_acq3",  1, 1, 0, 4'b1111, 'h08, 3, 0, 0, 0, 0, 0);
        v("c_lock",  1, 1, 0, 4'b1110, 'h10, 4, 1, 0, 0, 0, 0);
        v("c_lk5",   1, 1, 0, 4'b1100, 'h20, 5, 1, 0, 0, 0, 0);
        v("c_lk6",   1, 1, 0, 4'b1000, 'h40, 6, 1, 0, 0, 0, 0);
        v("c_lk7",   1, 1, 0, 4'b0000, 'h80, 7, 1, 0, 0, 0, 0);

        for (int r = 0; r < 5; r++) begin
            for (int p = 0; p < 8; p++) begin
                v($sformatf("rev%0d_p%0d", r, p), 1, 1, 0,
                  jc[(p + 1) % 8], 1 << p, p, 1, 0, 0,
                  (p == 0) ? 1 : 0, rc5[r]);
            end
        end

        v("rev6",    1, 1, 0, 4'b0101, 'h01, 0, 1, 0, 0, 1, 2);
        v("err1",    1, 1, 0, 4'b1010, 'h00, 0, 0, 1, 1, 0, 2);
        v("err2",    1, 1, 0, 4'b0101, 'h00, 0, 0, 1, 2, 0, 2);
        v("err3",    1, 1, 0, 4'b1010, 'h00, 0, 0, 1, 3, 0, 2);
        v("err4",    1, 1, 0, 4'b0100, 'h00, 0, 0, 1, 3, 0, 2);
        v("err5",    1, 1, 0, 4'b1011, 'h00, 0, 0, 1, 3, 0, 2);
        v("err6_clr", 1, 1, 1, 4'b0000, 'h00, 0, 0, 1, 0, 0, 0);
        v("zero_jmp2", 1, 1, 0, 4'b0000, 'h01, 0, 0,
          (RS != 0) ? 0 : 1, EC, 0, 0);
        v("stall",   1, 1, 0, 4'b0001, 'h01, 0, 0, 0, EC, 0, 0);
        v("a1",      1, 1, 0, 4'b0011, 'h02, 1, 0, 0, EC, 0, 0);
        v("a2",      1, 1, 0, 4'b0111, 'h04, 2, 0, 0, EC, 0, 0);
        v("a3",      1, 1, 0, 4'b1111, 'h08, 3, 0, 0, EC, 0, 0);
        v("a4_lock", 1, 1, 0, 4'b1110, 'h10, 4, 1, 0, EC, 0, 0);

        @(negedge Clock);
        #1;
        Reset = 1'b0;
        #1;
        q.push_back(mk(cyc, "async_rst", 0, 0, 0, 0, 0, 0, 0));
        ->ev_async;
        @(posedge Clock);
        #1;

        v("in_rst",  0, 1, 0, 4'b0000, 'h00, 0, 0, 0, 0, 0, 0);
        v("rel2",    1, 1, 0, 4'b0001, 'h00, 0, 0, 0, 0, 0, 0);
        v("idle2",   1, 1, 0, 4'b0011, 'h02, 1, 0, 0, 0, 0, 0);
        v("r_acq1",  1, 1, 0, 4'b0111, 'h04, 2, 0, 0, 0, 0, 0);

        repeat (2) @(negedge Clock);
        #1;
        n_chk++;
        if (q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/johnson_phase_monitor.md
# johnson_phase_monitor

Downstream consumer of the 4-bit Johnson counter output. Samples the 4-bit Johnson code every cycle and decodes it into a one-hot 8-phase bus and a binary phase index. It checks every code transition against the legal Johnson sequence, maintains a lock state machine, and keeps a saturating error counter and a wrapping revolution counter for system-level health monitoring.

## Interface
- LOCK_COUNT, 4, consecutive legal steps required to assert Locked (range 1..15)
- ERR_W, 8, width of Err_count
- REV_W, 16, width of Rev_count

- Clock  input  1  sole clock, rising-edge
- Reset  input  1  one clock; reset is asynchronous and active-low
- Enable  input  1  sample qualifier; 0 = hold all state
- Clear  input  1  synchronous zeroing of Err_count and Rev_count
- Count_in  input  4  Johnson code from the upstream counter
- Phase_out  output  8  one-hot decoded phase; 0 when code is illegal
- Phase_idx  output  3  binary phase index 0..7
- Locked  output  1  sequence lock status
- Error_pulse  output  1  one-cycle strobe per transition error
- Err_count  output  ERR_W  saturating error count
- Rev_pulse  output  1  one-cycle strobe per completed revolution
- Rev_count  output  REV_W  wrapping revolution count

## Operation
- Legal codes and phases:
  - 0000=0, 0001=1, 0011=2, 0111=3
  - 1111=4, 1110=5, 1100=6, 1000=7
- Successor of code c is {c[2:0], ~c[3]}.
- Stage 1 registers Count_in into samp when Enable=1. The stage 1 register also holds prev, the last classified code.
- Stage 2 classifies samp against prev and updates all outputs. Classes:
  - STALL: samp == prev. Legal; the lock counter is unchanged.
  - STEP: samp is the successor of prev. Legal; the lock counter increments, saturating at LOCK_COUNT.
  - RESYNC: samp == 0000 and not a STEP. Not an error; state goes to ACQ and the lock counter clears (see Configuration).
  - ERROR: samp is one of the 8 non-Johnson codes, or any other non-successor jump.
- State machine (reset state IDLE):
  - IDLE: first enabled sample -> ACQ. The sample is decoded, but no error checking is done.
  - ACQ: STEP when the counter reaches LOCK_COUNT -> LOCKED. ERROR -> ACQ with the counter cleared.
  - LOCKED: ERROR or RESYNC -> ACQ with the counter cleared. STALL and STEP stay in LOCKED.
- Locked = (state == LOCKED).
- On an illegal code: Phase_out = 0 and Phase_idx holds its previous value.
- On ERROR:
  - Error_pulse = 1 for one cycle.
  - Err_count increments and saturates at all-ones.
- On a STEP from 1000 to 0000 while in LOCKED:
  - Rev_pulse = 1 for one cycle.
  - Rev_count increments and wraps from all-ones to 0.
- Clear=1 zeroes Err_count and Rev_count. It does not affect the state machine or the pulses.
- Clear and an increment in the same cycle: Clear wins (counter = 0), and the pulse still fires.
- Enable=0:
  - samp, prev, state, the counters and Phase_out/Phase_idx hold.
  - Error_pulse and Rev_pulse are 0.
  - Clear still acts.

## Timing
- Latency: Count_in sampled at edge k appears on Phase_out, Phase_idx and the pulses after edge k+1.
- Locked asserts after the same edge that registers the LOCK_COUNT-th consecutive STEP.
- Pulses last exactly one Clock cycle per qualifying enabled sample.
- Reset low forces the following immediately, without a clock edge:
  - samp = prev = 0000, state = IDLE, lock counter = 0.
  - Phase_out = 0, Phase_idx = 0, Locked = 0.
  - Error_pulse = 0, Rev_pulse = 0, Err_count = 0, Rev_count = 0.
- Release is synchronous to the next Clock edge. The first enabled sample after release is treated as the IDLE entry sample.

## Configuration
- JOHNSON_MONITOR_RESYNC_EN:
  - Defined: the RESYNC class exists. A non-successor jump to 0000 (an upstream counter reset) restarts acquisition without an error.
  - Undefined: a non-successor jump to 0000 is classified ERROR, with Error_pulse and an Err_count increment.
  - Phase decoding is identical in both builds.

## Test plan
- Lock acquisition: reset, LOCK_COUNT=4, feed 0000,0001,0011,0111,1111 -> Locked rises after the edge registering 1111; Phase_out = 0x10, Phase_idx = 4.
- Illegal code: while locked, drive 0101 -> Error_pulse one cycle, Err_count = 1, Phase_out = 0, Locked = 0.
- Revolution and wrap: with REV_W=2 and locked, drive 1000->0000 five times -> five Rev_pulses, and Rev_count reads 1,2,3,0,1.
- Resync, both builds: locked at 0011, then drive 0000:
  - With JOHNSON_MONITOR_RESYNC_EN: Err_count unchanged, state ACQ.
  - Without it: Err_count +1 and Error_pulse.
- Saturation and Clear: ERR_W=2, inject 5 errors -> Err_count = 3. Then Clear=1 in the same cycle as a 6th error -> Err_count = 0 and Error_pulse = 1.
- Async reset: assert Reset low mid-LOCKED between clock edges -> all outputs 0 before the next edge. Enable=0 during a legal stream -> outputs frozen and pulses 0.
